// File: rtl/signal_delay_var.sv
// signal_delay_var: variable-length data/valid delay line with fill tracking and lock indication
module signal_delay_var #(
   parameter int WIDTH_SIGNAL = 8,
   parameter int MAX_DELAY = 16,
   parameter logic [WIDTH_SIGNAL-1:0] RESET_VALUE = '0,
   localparam int DW = $clog2(MAX_DELAY + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    flush,
   input  logic [DW-1:0]           dly_sel,
   input  logic                    in_valid,
   input  logic [WIDTH_SIGNAL-1:0] in_data,
   output logic                    out_valid,
   output logic [WIDTH_SIGNAL-1:0] out_data,
   output logic                    locked,
   output logic                    dly_err
);
   localparam int AW = $clog2(MAX_DELAY);
   typedef enum logic {FILL, RUN} state_t;
   state_t state;
   logic [WIDTH_SIGNAL-1:0] stage [MAX_DELAY];
   logic [MAX_DELAY-1:0] vld;
   logic [DW-1:0] fill_cnt, dly_cur, d_eff;
   logic [AW-1:0] idx;
   logic illegal, restart;
   always_comb begin
      illegal = dly_sel == '0 || dly_sel > DW'(MAX_DELAY);
      d_eff = dly_sel == '0 ? DW'(1) : (dly_sel > DW'(MAX_DELAY) ? DW'(MAX_DELAY) : dly_sel);
      restart = flush || d_eff != dly_cur;
      idx = AW'(dly_cur - DW'(1));
   end
   // A restart (flush or delay change) drops validity but leaves data stages untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_DELAY; i++) stage[i] <= RESET_VALUE;
         vld <= '0;
         fill_cnt <= '0;
         dly_cur <= DW'(MAX_DELAY);
         state <= FILL;
         dly_err <= 1'b0;
      end else begin
         dly_err <= illegal;
         if (restart) begin
            dly_cur <= d_eff;
            vld <= '0;
            fill_cnt <= '0;
            state <= FILL;
         end else if (ce) begin
            stage[0] <= in_data;
            for (int i = 1; i < MAX_DELAY; i++) stage[i] <= stage[i-1];
            vld <= {vld[MAX_DELAY-2:0], in_valid};
            if (state == FILL) begin
               fill_cnt <= fill_cnt + DW'(1);
               if (fill_cnt == dly_cur - DW'(1)) state <= RUN;
            end
         end
      end
   end
   assign locked = state == RUN;
   assign out_data = stage[idx];
   assign out_valid = locked && vld[idx];
endmodule
